// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and a
// small helper that tells whether a state is qualifying a candidate change.
package debounce_pkg;

  // 2-bit state encodings; bit 1 is the stable level the state belongs to
  localparam logic [1:0] ENC_STABLE_LO = 2'b00;
  localparam logic [1:0] ENC_CHECK_HI  = 2'b01;
  localparam logic [1:0] ENC_STABLE_HI = 2'b10;
  localparam logic [1:0] ENC_CHECK_LO  = 2'b11;

  typedef enum logic [1:0] {
    STABLE_LO = ENC_STABLE_LO,
    CHECK_HI  = ENC_CHECK_HI,
    STABLE_HI = ENC_STABLE_HI,
    CHECK_LO  = ENC_CHECK_LO
  } state_t;

  // True while a candidate level change is being qualified
  function automatic logic is_check(input state_t st);
    return (st == CHECK_HI) || (st == CHECK_LO);
  endfunction

endpackage

// File: rtl/debounce_fsm_sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value, used to
// bring an asynchronous pad signal into the clk domain.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/debounce_fsm.sv
// Switch/button debouncer. A level change on the sampled input is accepted
// only after it has been held across STABLE_TICKS consecutive ticks from the
// shared time ticker; acceptance updates db_level and pulses rise or fall.
// Build option: define DEBOUNCE_FSM_SYNC_EN to put a 2-flop synchronizer
// in front of the FSM (adds 2 cycles of input latency). Without it raw_in
// must already be synchronous to clk.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter bit RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw_in,
  output logic db_level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int                CNT_W       = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_TICKS - 1);
  localparam state_t            RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             w_s;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_level;
  logic             w_level_next;
  logic             r_rise;
  logic             w_rise_next;
  logic             r_fall;
  logic             w_fall_next;
  logic             r_busy;
  logic             w_busy_next;

`ifdef DEBOUNCE_FSM_SYNC_EN
  sync_2ff #(
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (raw_in),
    .o_q     (w_s)
  );
`else
  assign w_s = raw_in;
`endif

  // State, counter and all outputs registered together from next-state logic
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RESET_STATE;
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state logic: a mismatching input aborts before a same-cycle tick is counted
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_next = CHECK_HI;
          w_cnt_next   = '0;
        end
      end
      CHECK_HI: begin
        if (!w_s) begin
          w_state_next = STABLE_LO;
          w_cnt_next   = '0;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_next = STABLE_HI;
            w_cnt_next   = '0;
            w_level_next = 1'b1;
            w_rise_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_next = CHECK_LO;
          w_cnt_next   = '0;
        end
      end
      CHECK_LO: begin
        if (w_s) begin
          w_state_next = STABLE_HI;
          w_cnt_next   = '0;
        end else if (tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_next = STABLE_LO;
            w_cnt_next   = '0;
            w_level_next = 1'b0;
            w_fall_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = RESET_STATE;
        w_cnt_next   = '0;
      end
    endcase
    w_busy_next = is_check(w_state_next);
  end

  assign db_level = r_level;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign busy     = r_busy;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed self-checking bench for debounce_fsm (STABLE_TICKS=4).
// Works in both builds; input-path latency follows DEBOUNCE_FSM_SYNC_EN.
module tb_debounce_fsm;

`ifdef DEBOUNCE_FSM_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic tick;
  logic raw_in;
  logic db0, rise0, fall0, busy0;
  logic db1, rise1, fall1, busy1;

  int tests_run    = 0;
  int tests_failed = 0;
  int rise_cnt     = 0;
  int fall_cnt     = 0;

  always #5 clk = ~clk;

  debounce_fsm #(.STABLE_TICKS(4), .RESET_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .raw_in(raw_in),
    .db_level(db0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  debounce_fsm #(.STABLE_TICKS(4), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .raw_in(raw_in),
    .db_level(db1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  task automatic check_bit(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  // One clock with the given tick value; outputs are sampled 1 ns after the edge
  task automatic cycle(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (rise0) rise_cnt++;
    if (fall0) fall_cnt++;
  endtask

  // n ticks, each preceded by gap-1 idle cycles; ends right after the last tick edge
  task automatic ticks_spaced(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      repeat (gap - 1) cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tick    = 1'b0;
    raw_in  = 1'b0;
    #1;

    // Reset held while raw_in toggles
    for (int i = 0; i < 3; i++) begin
      raw_in = i[0];
      tick   = 1'b1;
      @(posedge clk);
      #1;
      check_bit("rst db_level L0", db0, 0);
      check_bit("rst db_level L1", db1, 1);
      check_bit("rst pulses/busy", {rise0, fall0, busy0, rise1, fall1, busy1}, 0);
    end
    tick   = 1'b0;
    raw_in = 1'b0;
    reset_n = 1'b1;
    repeat (3) cycle(1'b0);
    check_bit("idle busy", busy0, 0);
    check_bit("idle db_level", db0, 0);

    // Clean press, tick every 10 cycles
    rise_cnt = 0;
    raw_in = 1'b1;
    repeat (LAT + 1) cycle(1'b0);
    check_bit("press busy", busy0, 1);
    ticks_spaced(3, 10);
    check_bit("press rise after 3 ticks", rise0, 0);
    check_bit("press db after 3 ticks", db0, 0);
    ticks_spaced(1, 10);
    check_bit("press rise after 4 ticks", rise0, 1);
    check_bit("press db after 4 ticks", db0, 1);
    check_bit("press busy done", busy0, 0);
    cycle(1'b0);
    check_bit("press rise one cycle", rise0, 0);
    for (int i = 0; i < 20; i++) cycle(i % 10 == 9);
    check_bit("press rise count", rise_cnt, 1);
    check_bit("press db hold", db0, 1);

    // Release
    fall_cnt = 0;
    raw_in = 1'b0;
    repeat (LAT + 1) cycle(1'b0);
    check_bit("release busy", busy0, 1);
    ticks_spaced(3, 10);
    check_bit("release fall after 3 ticks", fall0, 0);
    check_bit("release db after 3 ticks", db0, 1);
    ticks_spaced(1, 10);
    check_bit("release fall after 4 ticks", fall0, 1);
    check_bit("release db after 4 ticks", db0, 0);
    cycle(1'b0);
    check_bit("release fall one cycle", fall0, 0);
    check_bit("release fall count", fall_cnt, 1);
    check_bit("release no rise", rise_cnt, 1);

    // Bounce: 1,0,1,0 every 3 cycles with tick every cycle, then hold 1
    rise_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      raw_in = (p % 2 == 0);
      repeat (3) cycle(1'b1);
    end
    check_bit("bounce no rise", rise_cnt, 0);
    check_bit("bounce db", db0, 0);
    check_bit("bounce busy", busy0, 0);
    raw_in = 1'b1;
    repeat (LAT + 1) cycle(1'b0);
    ticks_spaced(3, 5);
    check_bit("bounce rise after 3 ticks", rise0, 0);
    ticks_spaced(1, 5);
    check_bit("bounce rise after 4 ticks", rise0, 1);
    cycle(1'b0);
    check_bit("bounce rise count", rise_cnt, 1);

    // Return low before the abort scenario
    raw_in = 1'b0;
    repeat (LAT + 1) cycle(1'b0);
    ticks_spaced(4, 2);
    cycle(1'b0);
    check_bit("back low db", db0, 0);

    // Abort on tick collision at cnt=3
    rise_cnt = 0;
    raw_in = 1'b1;
    repeat (LAT + 1) cycle(1'b0);
    repeat (3) cycle(1'b1);
    check_bit("abort busy at cnt3", busy0, 1);
    raw_in = 1'b0;
    repeat (LAT) cycle(1'b0);
    cycle(1'b1);
    check_bit("abort busy", busy0, 0);
    check_bit("abort rise", rise0, 0);
    check_bit("abort db", db0, 0);
    repeat (10) cycle(1'b1);
    check_bit("abort rise count", rise_cnt, 0);

    // Reset in the middle of CHECK_HI with cnt=2
    raw_in = 1'b1;
    repeat (LAT + 1) cycle(1'b0);
    repeat (2) cycle(1'b1);
    check_bit("midrst busy before", busy0, 1);
    reset_n = 1'b0;
    #1;
    check_bit("midrst busy async", busy0, 0);
    check_bit("midrst db async", db0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rise_cnt = 0;
    repeat (LAT + 1) cycle(1'b0);
    check_bit("midrst requalify busy", busy0, 1);
    repeat (3) cycle(1'b1);
    check_bit("midrst no early rise", rise_cnt, 0);
    check_bit("midrst db early", db0, 0);
    cycle(1'b1);
    check_bit("midrst rise after 4 ticks", rise0, 1);
    check_bit("midrst db after 4 ticks", db0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debounce_fsm.md
# debounce_fsm

- **Purpose:** Debounces one mechanical switch or button input and produces a clean level plus single-cycle edge pulses.
- **Tick input:** Consumes the periodic single-cycle tick produced by the team's free-running time ticker.
- **Filter rule:** A candidate level change is accepted only after the input has stayed at the new value across STABLE_TICKS consecutive ticks.
- **Placement:** Sits between the pad/input synchronizer and the control logic that reacts to button presses.

## Interface
Parameters:
- STABLE_TICKS, default 4: number of ticks the new level must be held; legal range 1..255.
- RESET_LEVEL, default 0: debounced level and assumed input level after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- tick  input  1  one-cycle pulse from the time ticker; arbitrary period ≥ 1 cycle.
- raw_in  input  1  noisy, asynchronous switch input.
- db_level  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse when db_level goes 0→1, registered.
- fall  output  1  one-cycle pulse when db_level goes 1→0, registered.
- busy  output  1  high while a candidate change is being qualified (CHECK states).

## Operation
- **Sampled input:** s is raw_in after the optional synchronizer (see Configuration).
- **State machine:** four states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
- **STABLE_LO:** s=1 → CHECK_HI, cnt←0. Otherwise hold.
- **CHECK_HI:**
  - s=0 → STABLE_LO. This is an abort: no pulse, cnt←0.
  - Else, if tick: when cnt = STABLE_TICKS−1 → STABLE_HI, db_level←1, rise←1. Otherwise cnt←cnt+1.
- **STABLE_HI / CHECK_LO:** mirror of the above with polarity inverted. Acceptance asserts fall.
- **Abort priority:** a mismatching s in the same cycle as tick aborts; the tick is not counted.
- **Counter:** width $clog2(STABLE_TICKS+1). Cleared on entry to any state. Never wraps, because it is bounded by STABLE_TICKS−1.
- **Effective filter time:** between (STABLE_TICKS−1)·T_tick and STABLE_TICKS·T_tick, because the first tick may arrive immediately.
- **Pulses:** rise and fall are mutually exclusive and never asserted in consecutive cycles. busy = (state ∈ {CHECK_HI, CHECK_LO}).
- **Tick stuck high:** a tick held high for many cycles counts once per cycle. Legal, but it makes the filter time STABLE_TICKS cycles.

## Timing
- **Reset values:**
  - state = STABLE_HI if RESET_LEVEL else STABLE_LO.
  - db_level = RESET_LEVEL; rise = fall = busy = 0; cnt = 0.
  - Synchronizer flops = RESET_LEVEL.
- **Latency, raw_in to s:** 2 cycles with the synchronizer, 0 without.
- **Latency, qualifying tick to outputs:** db_level and rise/fall change on the clock edge ending the cycle in which the qualifying tick is sampled.
- **State vs. outputs:** the state update and the output update occur on the same edge, since all outputs are registered from next-state logic.
- **Reset mid-qualification:** returns to the reset state immediately (asynchronous). Any pending change is discarded, with no pulse.
- **Reset deassertion:** synchronous to clk is assumed at system level. No tick is counted in the first cycle after release.

## Configuration
- **Macro:** DEBOUNCE_FSM_SYNC_EN.
- **Defined:** raw_in passes through a 2-flop synchronizer before the FSM; 2-cycle added latency.
- **Undefined:** raw_in feeds the FSM directly. Use only when the source is already synchronous to clk.
- **Unaffected:** all other behaviour is identical in both builds.

## Structure
- **Shared package (debounce_pkg):** state enum (STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO) and the 2-bit state encoding constants.
- **Sub-module:** sync_2ff, a generic reset-valued 2-flop synchronizer. Instantiated under DEBOUNCE_FSM_SYNC_EN.
- **Time base:** the tick generator stays external and is shared between debouncers.

## Test plan
- **Reset:** RESET_LEVEL=0, hold reset_n=0 while raw_in toggles → db_level=0, rise=fall=busy=0 throughout. Repeat with RESET_LEVEL=1 → db_level=1.
- **Clean press:** STABLE_TICKS=4, tick every 10 cycles. Raise raw_in and hold for 60 cycles → busy high, then rise pulses exactly once (1 cycle) on the edge after the 4th tick; db_level=1 from then on.
- **Bounce:** raw_in toggles 1,0,1,0 every 3 cycles, then holds 1 → no rise during the toggling. Exactly one rise after 4 clean ticks.
- **Abort on tick collision:** in CHECK_HI with cnt=3, drive s=0 in the same cycle as tick → returns to STABLE_LO, no rise, busy falls next edge.
- **Release:** from db_level=1, drop raw_in and hold → single fall pulse after 4 ticks; db_level=0.
- **Reset mid-check:** assert reset_n=0 during CHECK_HI with cnt=2 → immediate return to reset state; no rise after release even though raw_in=1 is still pending, until 4 new ticks elapse.
